cla_sub_pipe: RTL and testbench

- Two-stage pipelined 32-bit subtractor with borrow-in and borrow-out.
- Built on the same 4-bit carry-lookahead block structure as the team's clocked CLA adder. It is the inverse-operation counterpart: it computes a − b − bi as a + ~b + ~bi.
- Sits beside the clocked adder in the datapath.
- Valid/ready handshake on both sides, so it can be backpressured by the consumer.

---
 rtl/cla_sub_pipe.sv | 159 +++++++++++++++
 tb/tb_cla_sub_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_sub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_sub_pipe : two-stage 32-bit CLA subtractor, a - b - bi, valid/ready  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

// One half-width lookahead adder built from 4-bit carry-lookahead groups.
module cla_sub_half #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] nb,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int NG = N / 4;

    logic [NG:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar k = 0; k < NG; k++) begin : g_grp
            logic [3:0] w_g;
            logic [3:0] w_p;
            logic [3:0] w_ci;
            logic       w_gg;
            logic       w_gp;

            assign w_g = a[4*k +: 4] & nb[4*k +: 4];
            assign w_p = a[4*k +: 4] ^ nb[4*k +: 4];

            assign w_ci[0] = w_c[k];
            assign w_ci[1] = w_g[0] | (w_p[0] & w_c[k]);
            assign w_ci[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[k]);
            assign w_ci[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                           | (w_p[2] & w_p[1] & w_p[0] & w_c[k]);

            assign w_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                        | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
            assign w_gp = &w_p;

            assign w_c[k+1]       = w_gg | (w_gp & w_c[k]);
            assign sum[4*k +: 4]  = w_p ^ w_ci;
        end
    endgenerate

    assign cout = w_c[NG];
endmodule

module cla_sub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf,
    output logic             zero
);
    localparam int L = WIDTH / 2;

    logic         r_s1_valid;
    logic [L-1:0] r_s1_sum_lo;
    logic         r_s1_cmid;
    logic [L-1:0] r_s1_a_hi;
    logic [L-1:0] r_s1_nb_hi;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             r_ovf;
    logic             r_zero;

    logic             w_adv1;
    logic             w_adv2;
    logic [L-1:0]     w_nb_lo;
    logic [L-1:0]     w_lo_sum;
    logic             w_lo_cout;
    logic [L-1:0]     w_hi_sum;
    logic             w_hi_cout;
    logic [WIDTH-1:0] w_d_next;
    logic             w_a_msb;
    logic             w_b_msb;

    assign w_adv2   = ~r_s2_valid | out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign in_ready = w_adv1;

    // Subtraction as a + ~b + ~bi.
    assign w_nb_lo = ~b[L-1:0];

    cla_sub_half #(.N(L)) u_lo (
        .a    (a[L-1:0]),
        .nb   (w_nb_lo),
        .cin  (~bi),
        .sum  (w_lo_sum),
        .cout (w_lo_cout)
    );

    cla_sub_half #(.N(L)) u_hi (
        .a    (r_s1_a_hi),
        .nb   (r_s1_nb_hi),
        .cin  (r_s1_cmid),
        .sum  (w_hi_sum),
        .cout (w_hi_cout)
    );

    assign w_d_next = {w_hi_sum, r_s1_sum_lo};
    assign w_a_msb  = r_s1_a_hi[L-1];
    assign w_b_msb  = ~r_s1_nb_hi[L-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum_lo <= '0;
            r_s1_cmid   <= 1'b0;
            r_s1_a_hi   <= '0;
            r_s1_nb_hi  <= '0;
            r_s2_valid  <= 1'b0;
            r_d         <= '0;
            r_bo        <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            // Empty stages may load don't-care data; only the valid bits matter.
            if (w_adv1) begin
                r_s1_valid  <= in_valid;
                r_s1_sum_lo <= w_lo_sum;
                r_s1_cmid   <= w_lo_cout;
                r_s1_a_hi   <= a[WIDTH-1:L];
                r_s1_nb_hi  <= ~b[WIDTH-1:L];
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                r_d        <= w_d_next;
                r_bo       <= ~w_hi_cout;
                r_ovf      <= (w_a_msb ^ w_b_msb) & (w_d_next[WIDTH-1] ^ w_a_msb);
                r_zero     <= (w_d_next == '0);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign d         = r_d;
    assign bo        = r_bo;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

`default_nettype wire

// File: tb/tb_cla_sub_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cla_sub_pipe : scoreboard bench for cla_sub_pipe                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cla_sub_pipe;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        bo;
    logic        ovf;
    logic        zero;

    cla_sub_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    logic [34:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {d, bo, ovf, zero}.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic bin);
        logic [32:0] full;
        logic [31:0] dd;
        logic        o;
        full = {1'b0, x} - {1'b0, y} - {32'd0, bin};
        dd   = full[31:0];
        o    = (x[31] ^ y[31]) & (dd[31] ^ x[31]);
        return {dd, full[32], o, (dd == 32'd0)};
    endfunction

    // Handshakes are evaluated at the negedge, where they match the next posedge.
    task automatic cycle();
        logic [34:0] e;
        @(negedge clk);
        acc = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("d", d, e[34:3]);
                check("bo", bo, e[2]);
                check("ovf", ovf, e[1]);
                check("zero", zero, e[0]);
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(model(a, b, bi));
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic bin);
        int t = 0;
        a = x; b = y; bi = bin; in_valid = 1'b1;
        do begin
            cycle();
            t++;
        end while (!acc && t < 50);
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && t < 100) begin
            cycle();
            t++;
        end
        check("drain_empty", sb.size(), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held_d;
        int          n_acc;
        int          t;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bi = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset pulse between edges
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 64'd0);
        check("rst_d", d, 64'd0);
        check("rst_flags", {bo, ovf, zero}, 64'd0);
        check("rst_in_ready", in_ready, 64'd1);
        #1;
        reset_n = 1'b1;

        // Single result and two-cycle latency
        send(32'd10, 32'd3, 1'b0);
        check("lat_not_yet", out_valid, 64'd0);
        @(posedge clk); #1;
        check("lat_out_valid", out_valid, 64'd1);
        check("lat_d", d, 64'd7);
        drain();

        // Directed corners
        send(32'd0, 32'd1, 1'b0);
        send(32'd5, 32'd4, 1'b1);
        send(32'h8000_0000, 32'd1, 1'b0);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send(32'h0001_0000, 32'd1, 1'b0);
        drain();

        // Backpressure: two accepts fill the pipe, then stall
        out_ready = 1'b0;
        n_acc = 0;
        t = 0;
        in_valid = 1'b1;
        while (n_acc < 2 && t < 20) begin
            a = 32'h1000 * (n_acc + 1); b = 32'h11 * (n_acc + 3); bi = n_acc[0];
            cycle();
            if (acc) n_acc++;
            t++;
        end
        check("bp_in_ready_low", in_ready, 64'd0);
        check("bp_out_valid", out_valid, 64'd1);
        held_d = d;
        a = 32'hDEAD_0000; b = 32'h0000_BEEF; bi = 1'b1;
        repeat (3) cycle();
        check("bp_no_accept", acc, 64'd0);
        check("bp_d_hold", d, held_d);
        check("bp_still_full", in_ready, 64'd0);
        out_ready = 1'b1;
        t = 0;
        while (n_acc < 4 && t < 20) begin
            cycle();
            if (acc) begin
                n_acc++;
                a = 32'hFFFF_0001; b = 32'h0001_FFFF; bi = 1'b0;
            end
            t++;
        end
        in_valid = 1'b0;
        check("bp_accepts", n_acc, 64'd4);
        drain();

        // Random traffic with random backpressure
        in_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!in_valid || acc) begin
                a  = $urandom;
                b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
                bi = 1'($urandom_range(0, 1));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid = 1'b0;
        drain();

        // Reset with two transactions in flight
        out_ready = 1'b0;
        send(32'd100, 32'd1, 1'b0);
        send(32'd200, 32'd2, 1'b0);
        check("mid_full", out_valid, 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 64'd0);
        check("mid_rst_d", d, 64'd0);
        check("mid_rst_in_ready", in_ready, 64'd1);
        sb.delete();
        #2;
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) cycle();
        check("mid_no_stale", out_valid, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
